mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
- Multi-cycle MIPS control unit. It is the successor to the single-cycle combinational controller.
- It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and drives the shared-memory multi-cycle datapath.
- It talks to a variable-latency unified memory through a req/ready handshake, with timeout and illegal-opcode detection.
- It sits beside the datapath in the top-level mips module and replaces the Ctrler instance.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles a memory request may wait for mem_ready before the bus-error trap; legal range 1..255.
- TO_W, 8: width of the timeout counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- instr  in  32  latched IR contents from the datapath.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  request is a write (valid with mem_req).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  2  next PC: 0 = ALU, 1 = ALUOut (branch), 2 = jump target, 3 = rs (jr).
- reg_write  out  1  register file write enable.
- reg_dst  out  2  write register: 0 = rt, 1 = rd, 2 = $31.
- mem_to_reg  out  2  write-back data: 0 = ALUOut, 1 = MDR, 2 = PC.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B: 0 = rt, 1 = constant 4, 2 = ext imm, 3 = ext imm << 2.
- imm_src  out  2  immediate extension: 0 = sign, 1 = zero, 2 = lui (imm << 16).
- alu_op  out  3  0 = add, 1 = sub, 2 = or.
- illegal  out  1  sticky illegal-instruction flag.
- bus_err  out  1  sticky memory-timeout flag.

Behaviour:
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr. nop is sll $0, which decodes as an R-type with funct 0 and writes $0.
- While reset = 0: state is FETCH, the timeout counter and sticky flags are 0, and every output is forced to 0.
- States and transitions:
  - FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=add. Hold until mem_ready. In the mem_ready cycle, ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - DECODE: alu_src_a=0, alu_src_b=3, alu_op=add (branch target into ALUOut). Dispatch on opcode/funct. An unknown opcode or R-type funct goes to ILLEGAL.
  - MEMADR (lw/sw): alu_src_a=1, alu_src_b=2, imm_src=0, alu_op=add. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD: mem_req=1, i_or_d=1. On mem_ready go to MEMWB.
  - MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, then FETCH.
  - MEMWR: mem_req=1, mem_we=1, i_or_d=1. On mem_ready go to FETCH.
  - RTYPE_EX: alu_src_a=1, alu_src_b=0, alu_op from funct, then ALU_WB.
  - ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
  - IMM_EX (ori/lui): alu_src_a=1, alu_src_b=2, imm_src=1 for ori or 2 for lui, alu_op=or, then IMM_WB.
  - IMM_WB: reg_write=1, reg_dst=0, then FETCH.
  - BEQ_EX: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_src=1, pc_write=zero, then FETCH.
  - JUMP: pc_write=1, pc_src=2, then FETCH.
  - JAL: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2. The PC value written is the already-incremented PC+4. Then FETCH.
  - JR: pc_write=1, pc_src=3, then FETCH.
  - ILLEGAL, BUSERR: terminal. All strobes are 0; only reset exits.
- Latency in cycles, with 0-wait memory (mem_ready in the first request cycle): lw 5, sw 4, R/I-type 4, beq/j/jal/jr 3.
- Timeout counter:
  - Clears on every state entry.
  - Increments each cycle that mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0, go to BUSERR and set bus_err.
  - If mem_ready arrives in the same cycle the count would hit MEM_TIMEOUT, the transfer completes and there is no error.
- mem_ready while mem_req=0 is ignored.
- mem_req/mem_we/i_or_d stay stable until mem_ready; the request is never withdrawn.
- illegal and bus_err are set on entry to their state and held until reset.
- Reset asserted mid-request drops mem_req asynchronously; there is no completion.

Optional Feature:
- Macro: MIPS_MC_CTRL_PERF_EN.
- When defined, adds outputs cyc_cnt[31:0] and instr_cnt[31:0], both reset to 0.
  - cyc_cnt increments every non-reset cycle while not in a terminal state.
  - instr_cnt increments on each transition into FETCH from a completing state.
  - Both wrap modulo 2^32.
- When undefined, these ports and counters are absent.

Decomposition:
- Shared package mips_pkg holds:
  - opcode/funct constants: OP_RTYPE, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, FN_ADDU, FN_SUBU, FN_JR, FN_SLL.
  - state enumeration.
  - alu_op, pc_src, reg_dst, mem_to_reg and imm_src encodings.
- One natural sub-module, mips_mc_decode: combinational opcode/funct to next-state and alu_op decode, with an illegal indication.

Test Plan:
- Reset release, 0-wait memory, instr=addu $3,$1,$2 (0x00221821) -> states FETCH,DECODE,RTYPE_EX,ALU_WB; reg_write=1, reg_dst=1 in cycle 4; back in FETCH in cycle 5.
- lw $4,8($0) (0x8C040008) with mem_ready delayed 3 cycles on both accesses -> mem_req held stable, i_or_d=1 on the data access, completes in 11 cycles, mem_to_reg=1.
- beq with zero=1 and then zero=0 -> pc_write=1 with pc_src=1 in BEQ_EX only for zero=1; 3 cycles each.
- jal (0x0C000010) -> reg_dst=2, mem_to_reg=2, pc_src=2 in a single cycle; then jr $31 (0x03E00008) -> pc_src=3.
- Opcode 0x3F -> illegal=1 from the cycle after DECODE; all strobes 0 for 20 cycles; reset=0 clears it.
- MEM_TIMEOUT=4 with mem_ready never asserted -> bus_err=1 after 4 wait cycles. Repeat with mem_ready in wait cycle 4 -> no error.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the multi-cycle MIPS controller.
//   - opcode / funct field values of the supported instruction subset
//   - controller state enumeration
//   - datapath mux / ALU select encodings
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPE_EX, S_ALU_WB, S_IMM_EX, S_IMM_WB, S_BEQ_EX,
    S_JUMP, S_JAL, S_JR, S_ILLEGAL, S_BUSERR
  } state_e;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_OR     = 3'd2;

  localparam logic [1:0] PC_ALU     = 2'd0;
  localparam logic [1:0] PC_ALUOUT  = 2'd1;
  localparam logic [1:0] PC_JUMP    = 2'd2;
  localparam logic [1:0] PC_RS      = 2'd3;

  localparam logic [1:0] RD_RT      = 2'd0;
  localparam logic [1:0] RD_RD      = 2'd1;
  localparam logic [1:0] RD_RA      = 2'd2;

  localparam logic [1:0] WB_ALUOUT  = 2'd0;
  localparam logic [1:0] WB_MDR     = 2'd1;
  localparam logic [1:0] WB_PC      = 2'd2;

  localparam logic [1:0] IMM_SIGN   = 2'd0;
  localparam logic [1:0] IMM_ZERO   = 2'd1;
  localparam logic [1:0] IMM_LUI    = 2'd2;

endpackage

// File: rtl/mips_mc_decode.sv
// mips_mc_decode: combinational opcode/funct decode.
//   opcode, funct : instruction fields from the IR
//   next_state    : state to dispatch to from DECODE (S_ILLEGAL if unknown)
//   alu_op        : ALU operation for R-type execute
//   imm_src       : immediate extension for ori/lui
//   mem_write     : memory-reference instruction is a store
//   illegal_op    : opcode/funct not in the supported subset
module mips_mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_e     next_state,
  output logic [2:0] alu_op,
  output logic [1:0] imm_src,
  output logic       mem_write,
  output logic       illegal_op
);

  always_comb begin
    next_state = S_ILLEGAL;
    alu_op     = ALU_ADD;
    imm_src    = IMM_SIGN;
    mem_write  = (opcode == OP_SW);
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          // sll only ever appears as nop; it writes $0 so the ALU op is moot
          FN_SLL, FN_ADDU: next_state = S_RTYPE_EX;
          FN_SUBU: begin
            next_state = S_RTYPE_EX;
            alu_op     = ALU_SUB;
          end
          FN_JR:   next_state = S_JR;
          default: next_state = S_ILLEGAL;
        endcase
      end
      OP_LW, OP_SW: next_state = S_MEMADR;
      OP_ORI: begin
        next_state = S_IMM_EX;
        imm_src    = IMM_ZERO;
      end
      OP_LUI: begin
        next_state = S_IMM_EX;
        imm_src    = IMM_LUI;
      end
      OP_BEQ:  next_state = S_BEQ_EX;
      OP_J:    next_state = S_JUMP;
      OP_JAL:  next_state = S_JAL;
      default: next_state = S_ILLEGAL;
    endcase
    illegal_op = (next_state == S_ILLEGAL);
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS control unit driving a shared-memory
// datapath and a variable-latency unified memory (req/ready handshake).
//   clk, reset (async, active low), instr (latched IR), zero (ALU flag),
//   mem_ready -> mem_req/mem_we/i_or_d, datapath strobes and mux selects,
//   sticky illegal / bus_err flags.
// Optional build macro MIPS_MC_CTRL_PERF_EN adds cyc_cnt / instr_cnt.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  imm_src,
  output logic [2:0]  alu_op,
  output logic        illegal,
  output logic        bus_err
`ifdef MIPS_MC_CTRL_PERF_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] instr_cnt
`endif
);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;

  state_e     dec_state;
  logic [2:0] dec_alu_op;
  logic [1:0] dec_imm_src;
  logic       dec_mem_write;
  logic       dec_illegal_unused;
  logic       instr_unused;

  assign instr_unused = ^instr[25:6];

  mips_mc_decode u_dec (
    .opcode     (instr[31:26]),
    .funct      (instr[5:0]),
    .next_state (dec_state),
    .alu_op     (dec_alu_op),
    .imm_src    (dec_imm_src),
    .mem_write  (dec_mem_write),
    .illegal_op (dec_illegal_unused)
  );

  // Request states, independent of reset gating (counter is held in reset).
  logic in_req, wait_cyc, timeout;
  assign in_req   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign wait_cyc = in_req && !mem_ready;
  // Trap on the wait cycle that would bring the count to MEM_TIMEOUT;
  // a ready in that same cycle still completes.
  assign timeout  = wait_cyc && (to_q == TO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : (timeout ? S_BUSERR : S_FETCH);
      S_DECODE:   state_d = dec_state;
      S_MEMADR:   state_d = dec_mem_write ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = mem_ready ? S_MEMWB : (timeout ? S_BUSERR : S_MEMRD);
      S_MEMWR:    state_d = mem_ready ? S_FETCH : (timeout ? S_BUSERR : S_MEMWR);
      S_RTYPE_EX: state_d = S_ALU_WB;
      S_IMM_EX:   state_d = S_IMM_WB;
      S_MEMWB, S_ALU_WB, S_IMM_WB, S_BEQ_EX, S_JUMP, S_JAL, S_JR:
                  state_d = S_FETCH;
      default:    state_d = state_q;
    endcase
    if (state_d != state_q) to_d = '0;
    else if (wait_cyc)      to_d = to_q + 1'b1;
    else                    to_d = to_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
    end
  end

  // Outputs decode from the current state; gating with reset drops the
  // request immediately when reset asserts, even in FETCH.
  always_comb begin
    mem_req = 1'b0; mem_we = 1'b0; i_or_d = 1'b0; ir_write = 1'b0;
    pc_write = 1'b0; pc_src = PC_ALU; reg_write = 1'b0; reg_dst = RD_RT;
    mem_to_reg = WB_ALUOUT; alu_src_a = 1'b0; alu_src_b = 2'd0;
    imm_src = IMM_SIGN; alu_op = ALU_ADD; illegal = 1'b0; bus_err = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:   alu_src_b = 2'd3;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = WB_MDR;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          i_or_d  = 1'b1;
        end
        S_RTYPE_EX: begin
          alu_src_a = 1'b1;
          alu_op    = dec_alu_op;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = RD_RD;
        end
        S_IMM_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          imm_src   = dec_imm_src;
          alu_op    = ALU_OR;
        end
        S_IMM_WB:   reg_write = 1'b1;
        S_BEQ_EX: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
          pc_src    = PC_ALUOUT;
          pc_write  = zero;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
        end
        S_JAL: begin
          // PC already holds PC+4 from FETCH, so it is the link value
          pc_write   = 1'b1;
          pc_src     = PC_JUMP;
          reg_write  = 1'b1;
          reg_dst    = RD_RA;
          mem_to_reg = WB_PC;
        end
        S_JR: begin
          pc_write = 1'b1;
          pc_src   = PC_RS;
        end
        S_ILLEGAL:  illegal = 1'b1;
        S_BUSERR:   bus_err = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MIPS_MC_CTRL_PERF_EN
  logic [31:0] cyc_q, cyc_d, icnt_q, icnt_d;

  always_comb begin
    cyc_d  = cyc_q;
    icnt_d = icnt_q;
    if (state_q != S_ILLEGAL && state_q != S_BUSERR) cyc_d = cyc_q + 32'd1;
    if (state_d == S_FETCH && state_q != S_FETCH)    icnt_d = icnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q  <= '0;
      icnt_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      icnt_q <= icnt_d;
    end
  end

  assign cyc_cnt   = cyc_q;
  assign instr_cnt = icnt_q;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl. The driver walks each instruction
// through the reference behaviour, pushing the expected control word for
// every cycle; the monitor pops one per falling edge and compares.
module tb_mips_mc_ctrl;
  localparam int TMO = 4;

  typedef struct packed {
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b, imm_src;
    logic [2:0] alu_op;
    logic       illegal, bus_err;
  } cw_t;

  logic clk = 1'b0, reset = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [31:0] instr = '0;
  logic mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, alu_src_a;
  logic illegal, bus_err;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, imm_src;
  logic [2:0] alu_op;
`ifdef MIPS_MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif

  mips_mc_ctrl #(.MEM_TIMEOUT(TMO), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_op(alu_op), .illegal(illegal), .bus_err(bus_err)
`ifdef MIPS_MC_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  cw_t exp_q[$];
  int  total = 0, bad = 0, cyc = 0;

  // Monitor: one control word per cycle, sampled on the falling edge.
  always @(negedge clk) begin : mon
    cw_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, reg_write,
            reg_dst, mem_to_reg, alu_src_a, alu_src_b, imm_src, alu_op,
            illegal, bus_err};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL ctrl_word cyc=%0d instr=%h got=%h want=%h", cyc, instr, a, e);
      end
      cyc++;
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input cw_t c, input logic rdy, input logic z);
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(c);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_cycles(input int n);
    reset = 1'b0;
    repeat (n) step('0, rb(), rb());
  endtask

  function automatic cw_t fetch_w(input logic done);
    cw_t c = '0;
    c.mem_req = 1'b1; c.alu_src_b = 2'd1;
    c.ir_write = done; c.pc_write = done;
    return c;
  endfunction

  // Memory transfer answered after d not-ready cycles; allowed only while
  // the whole request stays within TMO cycles.
  task automatic mem_phase(input cw_t base, input cw_t fin, input int d, output bit to);
    to = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      if (k == d) begin
        step(fin, 1'b1, rb());
        return;
      end
      step(base, 1'b0, rb());
    end
    to = 1'b1;
  endtask

  task automatic terminal(input logic ill, input int n);
    cw_t c = '0;
    c.illegal = ill; c.bus_err = !ill;
    repeat (n) step(c, rb(), rb());
  endtask

  task automatic run_instr(input logic [31:0] ins, input int df, input int dd,
                           input int zf, output bit dead);
    cw_t c, b;
    bit to;
    logic [5:0] op, fn;
    logic z;
    reset = 1'b1;
    instr = ins;
    dead  = 1'b0;
    op = ins[31:26];
    fn = ins[5:0];
    mem_phase(fetch_w(1'b0), fetch_w(1'b1), df, to);
    if (to) begin terminal(1'b0, 8); dead = 1'b1; return; end
    c = '0; c.alu_src_b = 2'd3;
    step(c, rb(), rb());
    c = '0;
    if (op == 6'h23 || op == 6'h2B) begin
      c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
      step(c, rb(), rb());
      b = '0; b.mem_req = 1'b1; b.i_or_d = 1'b1; b.mem_we = (op == 6'h2B);
      mem_phase(b, b, dd, to);
      if (to) begin terminal(1'b0, 8); dead = 1'b1; return; end
      if (op == 6'h23) begin
        c = '0; c.reg_write = 1'b1; c.mem_to_reg = 2'd1;
        step(c, rb(), rb());
      end
    end else if (op == 6'h00 && (fn == 6'h00 || fn == 6'h21 || fn == 6'h23)) begin
      c.alu_src_a = 1'b1; c.alu_op = (fn == 6'h23) ? 3'd1 : 3'd0;
      step(c, rb(), rb());
      c = '0; c.reg_write = 1'b1; c.reg_dst = 2'd1;
      step(c, rb(), rb());
    end else if (op == 6'h00 && fn == 6'h08) begin
      c.pc_write = 1'b1; c.pc_src = 2'd3;
      step(c, rb(), rb());
    end else if (op == 6'h0D || op == 6'h0F) begin
      c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = 3'd2;
      c.imm_src = (op == 6'h0D) ? 2'd1 : 2'd2;
      step(c, rb(), rb());
      c = '0; c.reg_write = 1'b1;
      step(c, rb(), rb());
    end else if (op == 6'h04) begin
      z = (zf < 0) ? rb() : zf[0];
      c.alu_src_a = 1'b1; c.alu_op = 3'd1; c.pc_src = 2'd1; c.pc_write = z;
      step(c, rb(), z);
    end else if (op == 6'h02 || op == 6'h03) begin
      c.pc_write = 1'b1; c.pc_src = 2'd2;
      if (op == 6'h03) begin
        c.reg_write = 1'b1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2;
      end
      step(c, rb(), rb());
    end else begin
      terminal(1'b1, 20);
      dead = 1'b1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 19))
      0, 1, 14, 18: return {6'h23, r[25:0]};
      2, 3:         return {6'h2B, r[25:0]};
      4, 15, 17:    return {6'h00, r[25:6], 6'h21};
      5:            return {6'h00, r[25:6], 6'h23};
      6:            return {6'h00, r[25:6], 6'h00};
      7:            return {6'h0D, r[25:0]};
      8:            return {6'h0F, r[25:0]};
      9, 10, 16:    return {6'h04, r[25:0]};
      11:           return {6'h02, r[25:0]};
      12:           return {6'h03, r[25:0]};
      13:           return {6'h00, r[25:21], 15'h0, 6'h08};
      default: begin
        case ($urandom_range(0, 3))
          0:       return {6'h3F, r[25:0]};
          1:       return {6'h05, r[25:0]};
          2:       return {6'h08, r[25:0]};
          default: return {6'h00, r[25:6], 6'h20};
        endcase
      end
    endcase
  endfunction

  function automatic int rand_dly();
    if ($urandom_range(0, 29) == 0) return TMO + $urandom_range(0, 2);
    return $urandom_range(0, TMO - 1);
  endfunction

  initial begin : drv
    bit dead;
    @(posedge clk);
    #1;
    rst_cycles(2);
    run_instr(32'h00221821, 0, 0, -1, dead);   // addu $3,$1,$2
    run_instr(32'h8C040008, 3, 3, -1, dead);   // lw $4,8($0), slow memory
    run_instr(32'hAC040008, 1, 2, -1, dead);   // sw
    run_instr(32'h10220004, 0, 0, 1, dead);    // beq taken
    run_instr(32'h10220004, 0, 0, 0, dead);    // beq not taken
    run_instr(32'h0C000010, 0, 0, -1, dead);   // jal
    run_instr(32'h03E00008, 0, 0, -1, dead);   // jr $31
    run_instr(32'h3C01ABCD, 0, 0, -1, dead);   // lui
    run_instr(32'h34211234, 0, 0, -1, dead);   // ori
    run_instr(32'h00000000, 0, 0, -1, dead);   // nop
    run_instr(32'hFC000000, 0, 0, -1, dead);   // opcode 0x3F
    rst_cycles(2);
    run_instr(32'h00221821, 100, 0, -1, dead); // fetch never answered
    rst_cycles(2);
    run_instr(32'h00221821, TMO - 1, 0, -1, dead); // ready on last allowed cycle
    run_instr(32'h8C040008, 0, TMO, -1, dead);     // data access times out
    rst_cycles(1);
    // reset in the middle of a pending fetch
    reset = 1'b1;
    step(fetch_w(1'b0), 1'b0, 1'b0);
    step(fetch_w(1'b0), 1'b0, 1'b0);
    rst_cycles(2);
    for (int ep = 0; ep < 30; ep++) begin
      for (int i = 0; i < 12; i++) begin
        run_instr(rand_instr(), rand_dly(), rand_dly(), -1, dead);
        if (dead) break;
      end
      rst_cycles($urandom_range(1, 3));
    end
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
